// File: rtl/regs_file.sv
// -----------------------------------------------------------------------------
// regs_file -- index registers X and Y plus the two-latch stack pointer S,
// all attached to the precharged SB bus, with S also able to drive ADL.
//
// The SB bus is resolved as a wired-AND. An undriven line floats high, so
// every enabled source can only pull bits low. The external sources arrive
// already combined on SB_in.
//
// The stack pointer is split into an input latch (s_in) and an output latch
// (s_out). s_out copies s_in at every edge. Every read of S uses s_out, so a
// write through SB_S becomes visible two edges later. S is stable once both
// latches agree.
//
// Ports
//   PHI0             core clock, rising-edge active
//   RES              synchronous active-high reset
//   X_SB/Y_SB/S_SB   drive X, Y or s_out onto SB this cycle
//   SB_X/SB_Y/SB_S   load resolved SB into X, Y or s_in at the edge
//   S_S              refresh s_in from s_out at the edge (SB_S wins)
//   S_ADL            drive s_out onto ADL this cycle
//   SB_in            external SB sources, 8'hFF when idle
//   SB_out, SB_drv   resolved SB value, internal-driver indicator
//   ADL_out, ADL_drv stack-pointer drive onto ADL
//   X_reg/Y_reg/S_reg observe X, Y and s_out
//   SB_CONFLICT      sticky: two or more internal SB drivers in one cycle
// -----------------------------------------------------------------------------
module regs_file #(
  parameter logic [7:0] S_INIT = 8'h00
) (
  input  logic       PHI0,
  input  logic       RES,
  input  logic       Y_SB,
  input  logic       X_SB,
  input  logic       S_SB,
  input  logic       SB_X,
  input  logic       SB_Y,
  input  logic       SB_S,
  input  logic       S_S,
  input  logic       S_ADL,
  input  logic [7:0] SB_in,
  output logic [7:0] SB_out,
  output logic       SB_drv,
  output logic [7:0] ADL_out,
  output logic       ADL_drv,
  output logic [7:0] X_reg,
  output logic [7:0] Y_reg,
  output logic [7:0] S_reg,
  output logic       SB_CONFLICT
);

  logic [7:0] x_q;
  logic [7:0] y_q;
  logic [7:0] s_in;
  logic [7:0] s_out;
  logic       conflict_q;

  // A disabled source leaves the precharged line high.
  function automatic logic [7:0] bus_term(input logic en, input logic [7:0] val);
    return en ? val : 8'hFF;
  endfunction

  function automatic logic multi_drive(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign SB_out = SB_in & bus_term(X_SB, x_q) & bus_term(Y_SB, y_q)
                        & bus_term(S_SB, s_out);
  assign SB_drv  = X_SB | Y_SB | S_SB;
  assign ADL_out = bus_term(S_ADL, s_out);
  assign ADL_drv = S_ADL;

  assign X_reg       = x_q;
  assign Y_reg       = y_q;
  assign S_reg       = s_out;
  assign SB_CONFLICT = conflict_q;

  always_ff @(posedge PHI0) begin
    if (RES) begin
      x_q        <= 8'h00;
      y_q        <= 8'h00;
      s_in       <= S_INIT;
      s_out      <= S_INIT;
      conflict_q <= 1'b0;
    end else begin
      if (SB_X) x_q <= SB_out;
      if (SB_Y) y_q <= SB_out;
      if (SB_S)     s_in <= SB_out;
      else if (S_S) s_in <= s_out;
      // Old s_in moves forward. A write landing in s_in this edge appears
      // in s_out at the next edge.
      s_out <= s_in;
      if (multi_drive(X_SB, Y_SB, S_SB)) conflict_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regs_file.sv
// -----------------------------------------------------------------------------
// tb_regs_file -- directed vectors for regs_file, with S_INIT = 8'hFD.
// Each vector is one clock cycle. Inputs are applied after the falling edge.
// The combinational bus outputs are checked before the rising edge. The
// register state is checked just after the rising edge.
// -----------------------------------------------------------------------------
module tb_regs_file;

  localparam logic [7:0] SI = 8'hFD;

  logic       clk = 1'b0;
  logic       res, x_sb, y_sb, s_sb, sb_x, sb_y, sb_s, s_s, s_adl;
  logic [7:0] sb_in;
  logic [7:0] sb_out, adl_out, x_reg, y_reg, s_reg;
  logic       sb_drv, adl_drv, sb_conflict;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regs_file #(.S_INIT(SI)) dut (
    .PHI0       (clk),
    .RES        (res),
    .Y_SB       (y_sb),
    .X_SB       (x_sb),
    .S_SB       (s_sb),
    .SB_X       (sb_x),
    .SB_Y       (sb_y),
    .SB_S       (sb_s),
    .S_S        (s_s),
    .S_ADL      (s_adl),
    .SB_in      (sb_in),
    .SB_out     (sb_out),
    .SB_drv     (sb_drv),
    .ADL_out    (adl_out),
    .ADL_drv    (adl_drv),
    .X_reg      (x_reg),
    .Y_reg      (y_reg),
    .S_reg      (s_reg),
    .SB_CONFLICT(sb_conflict)
  );

  typedef struct {
    logic       res, x_sb, y_sb, s_sb, sb_x, sb_y, sb_s, s_s, s_adl;
    logic [7:0] sb_in;
    logic       chk_comb;
    logic [7:0] e_sb;
    logic       e_drv;
    logic [7:0] e_adl;
    logic [7:0] e_x, e_y, e_s;
    logic       e_cf;
  } vec_t;

  function automatic vec_t vv(
    input logic r, xs, ys, ss, sx, sy, sS, sSs, sa,
    input logic [7:0] si,
    input logic cc, input logic [7:0] esb, input logic edrv, input logic [7:0] eadl,
    input logic [7:0] ex, ey, es, input logic ecf);
    vec_t v;
    v.res = r; v.x_sb = xs; v.y_sb = ys; v.s_sb = ss; v.sb_x = sx; v.sb_y = sy;
    v.sb_s = sS; v.s_s = sSs; v.s_adl = sa; v.sb_in = si; v.chk_comb = cc;
    v.e_sb = esb; v.e_drv = edrv; v.e_adl = eadl;
    v.e_x = ex; v.e_y = ey; v.e_s = es; v.e_cf = ecf;
    return v;
  endfunction

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    res = v.res; x_sb = v.x_sb; y_sb = v.y_sb; s_sb = v.s_sb;
    sb_x = v.sb_x; sb_y = v.sb_y; sb_s = v.sb_s; s_s = v.s_s;
    s_adl = v.s_adl; sb_in = v.sb_in;
    #1;
    if (v.chk_comb) begin
      chk8({tag, ".sb_out"},  sb_out,  v.e_sb);
      chk1({tag, ".sb_drv"},  sb_drv,  v.e_drv);
      chk8({tag, ".adl_out"}, adl_out, v.e_adl);
      chk1({tag, ".adl_drv"}, adl_drv, v.s_adl);
    end
    @(posedge clk);
    #1;
    chk8({tag, ".x_reg"}, x_reg, v.e_x);
    chk8({tag, ".y_reg"}, y_reg, v.e_y);
    chk8({tag, ".s_reg"}, s_reg, v.e_s);
    chk1({tag, ".conflict"}, sb_conflict, v.e_cf);
  endtask

  vec_t tbl[11];

  initial begin
    res = 1'b1; x_sb = 0; y_sb = 0; s_sb = 0; sb_x = 0; sb_y = 0;
    sb_s = 0; s_s = 0; s_adl = 0; sb_in = 8'hFF;

    //          r xs ys ss sx sy sS sSs sa  sb_in  cc  e_sb  drv  e_adl   X      Y      S    cf
    tbl[0]  = vv(0, 0, 0, 0, 1, 0, 0, 0, 0, 8'h5A, 1, 8'h5A, 0, 8'hFF, 8'h5A, 8'h00, SI, 0);
    tbl[1]  = vv(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'hFF, 1, 8'h5A, 1, 8'hFF, 8'h5A, 8'h5A, SI, 0);
    tbl[2]  = vv(0, 1, 0, 0, 1, 0, 0, 0, 0, 8'hFF, 1, 8'h5A, 1, 8'hFF, 8'h5A, 8'h5A, SI, 0);
    tbl[3]  = vv(0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h0F, 1, 8'h0A, 1, 8'hFF, 8'h0A, 8'h5A, SI, 0);
    tbl[4]  = vv(0, 0, 1, 0, 1, 0, 0, 0, 0, 8'hFF, 1, 8'h5A, 1, 8'hFF, 8'h5A, 8'h5A, SI, 0);
    tbl[5]  = vv(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h33, 1, 8'h33, 0, SI,    8'h5A, 8'h5A, SI, 0);
    tbl[6]  = vv(0, 0, 0, 1, 0, 1, 0, 0, 0, 8'hFF, 1, SI,    1, 8'hFF, 8'h5A, SI,    SI, 0);
    tbl[7]  = vv(0, 0, 0, 0, 1, 0, 0, 0, 0, 8'hF0, 1, 8'hF0, 0, 8'hFF, 8'hF0, SI,    SI, 0);
    tbl[8]  = vv(0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h3C, 1, 8'h3C, 0, 8'hFF, 8'hF0, 8'h3C, SI, 0);
    tbl[9]  = vv(0, 1, 1, 0, 0, 0, 0, 0, 0, 8'hFF, 1, 8'h30, 1, 8'hFF, 8'hF0, 8'h3C, SI, 1);
    tbl[10] = vv(0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h7F, 1, 8'h7D, 1, SI,    8'hF0, 8'h3C, SI, 1);

    // Reset state: the first cycle has unknown pre-state, so only the
    // registers are checked. The second cycle also checks the idle buses.
    apply(vv(1, 0,0,0,0,0,0,0,0, 8'hFF, 0, 8'hFF, 0, 8'hFF, 8'h00, 8'h00, SI, 0), "rst0");
    apply(vv(1, 0,0,0,0,0,0,0,0, 8'hFF, 1, 8'hFF, 0, 8'hFF, 8'h00, 8'h00, SI, 0), "rst1");

    for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Conflict flag is sticky across idle cycles.
    for (int i = 0; i < 10; i++)
      apply(vv(0, 0,0,0,0,0,0,0,0, 8'hFF, 1, 8'hFF, 0, 8'hFF, 8'hF0, 8'h3C, SI, 1),
            $sformatf("idle%0d", i));

    // S write: invisible after edge 1, visible after edge 2, then stable under refresh.
    apply(vv(0, 0,0,0,0,0,1,0,0, 8'hC3, 1, 8'hC3, 0, 8'hFF, 8'hF0, 8'h3C, SI,    1), "sw1");
    apply(vv(0, 0,0,0,0,0,0,0,1, 8'hFF, 1, 8'hFF, 0, SI,    8'hF0, 8'h3C, 8'hC3, 1), "sw2");
    for (int i = 0; i < 4; i++)
      apply(vv(0, 0,0,0,0,0,0,1,1, 8'hFF, 1, 8'hFF, 0, 8'hC3, 8'hF0, 8'h3C, 8'hC3, 1),
            $sformatf("srf%0d", i));

    // SB_S beats S_S: with s_out = 22, write 11 with both strobes high.
    apply(vv(0, 0,0,0,0,0,1,0,0, 8'h22, 1, 8'h22, 0, 8'hFF, 8'hF0, 8'h3C, 8'hC3, 1), "pr1");
    apply(vv(0, 0,0,0,0,0,0,0,0, 8'hFF, 1, 8'hFF, 0, 8'hFF, 8'hF0, 8'h3C, 8'h22, 1), "pr2");
    apply(vv(0, 0,0,0,0,0,1,1,0, 8'h11, 1, 8'h11, 0, 8'hFF, 8'hF0, 8'h3C, 8'h22, 1), "pr3");
    apply(vv(0, 0,0,0,0,0,0,0,0, 8'hFF, 1, 8'hFF, 0, 8'hFF, 8'hF0, 8'h3C, 8'h11, 1), "pr4");

    // Reset beats loads. The buses still resolve from the current state.
    apply(vv(1, 1,0,0,1,0,1,0,1, 8'h77, 1, 8'h70, 1, 8'h11, 8'h00, 8'h00, SI, 0), "rstpri");

    // Reset between the s_in and s_out updates discards the pending value.
    apply(vv(0, 0,0,0,0,0,1,0,0, 8'h99, 1, 8'h99, 0, 8'hFF, 8'h00, 8'h00, SI, 0), "mid1");
    apply(vv(1, 0,0,0,0,0,0,0,0, 8'hFF, 1, 8'hFF, 0, 8'hFF, 8'h00, 8'h00, SI, 0), "mid2");
    apply(vv(0, 0,0,0,0,0,0,0,1, 8'hFF, 1, 8'hFF, 0, SI,    8'h00, 8'h00, SI, 0), "mid3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
